// File: rtl/diagv2_mmio_timer.sv
// rtl/diagv2_mmio_timer.sv - memory-mapped prescaled 64-bit machine timer with compare irq
// Optional auto-reload of MTIMECMP enabled by defining DIAGV2_TIMER_AUTORELOAD_EN.
module diagv2_mmio_timer #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [2:0]        memType,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              timer_irq
);

  logic [DATA_W-1:0]  mtime;
  logic [DATA_W-1:0]  mtimecmp;
  logic               en;
  logic               irqEn;
  logic               pend;
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] pcnt;

  logic [2:0]        byteOff;
  logic [2:0]        wordSel;
  logic [1:0]        sizeSel;
  logic              misaligned;
  logic [7:0]        sizeMask;
  logic [7:0]        byteMask;
  logic [DATA_W-1:0] bitMask;
  logic [DATA_W-1:0] wdShift;
  logic [DATA_W-1:0] regWord;
  logic [DATA_W-1:0] laneData;
  logic [DATA_W-1:0] rdVal;

  assign byteOff = addr[2:0];
  assign wordSel = addr[5:3];
  assign sizeSel = memType[1:0];
  assign wdShift = wd << {byteOff, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    sizeMask   = 8'h01;
    case (sizeSel)
      2'd1: begin misaligned = byteOff[0];      sizeMask = 8'h03; end
      2'd2: begin misaligned = |byteOff[1:0];   sizeMask = 8'h0F; end
      2'd3: begin misaligned = |byteOff;        sizeMask = 8'hFF; end
      default: ;
    endcase
    byteMask = sizeMask << byteOff;
    bitMask  = '0;
    for (int i = 0; i < 8; i++) bitMask[i*8 +: 8] = {8{byteMask[i]}};
  end

  logic wrEn, wrMtime, wrCmp, wrCtrl, wrPresc, pendClr;
  assign wrEn    = sel && we && !misaligned;
  assign wrMtime = wrEn && (wordSel == 3'd0);
  assign wrCmp   = wrEn && (wordSel == 3'd1);
  assign wrCtrl  = wrEn && (wordSel == 3'd2);
  assign wrPresc = wrEn && (wordSel == 3'd3);
  // W1C only when the store actually covers byte 0 of CTRL
  assign pendClr = wrCtrl && byteMask[0] && wdShift[2];

  logic [DATA_W-1:0] mtimeWr, cmpWr, ctrlWr, prescWr;
  assign mtimeWr = (mtime    & ~bitMask) | (wdShift & bitMask);
  assign cmpWr   = (mtimecmp & ~bitMask) | (wdShift & bitMask);
  assign ctrlWr  = ({{(DATA_W-3){1'b0}}, pend, irqEn, en} & ~bitMask) | (wdShift & bitMask);
  assign prescWr = ({{(DATA_W-PRESC_W){1'b0}}, prescale} & ~bitMask) | (wdShift & bitMask);

  logic tick, match;
  assign tick  = en && (pcnt == prescale);
  assign match = (mtime >= mtimecmp);

`ifdef DIAGV2_TIMER_AUTORELOAD_EN
  logic [DATA_W-1:0] reload;
  logic [DATA_W-1:0] reloadWr;
  logic              wrReload;
  logic              reloadHit;
  assign wrReload  = wrEn && (wordSel == 3'd4);
  assign reloadWr  = (reload & ~bitMask) | (wdShift & bitMask);
  // Reload compares against the value MTIME takes after this cycle's tick
  assign reloadHit = tick && !wrMtime && (reload != '0) && ((mtime + 1'b1) >= mtimecmp);
`endif

  logic unusedBits;
  assign unusedBits = ^{addr[ADDR_W-1:6], ctrlWr[DATA_W-1:3], prescWr[DATA_W-1:PRESC_W]};

  always_comb begin
    regWord = '0;
    case (wordSel)
      3'd0: regWord = mtime;
      3'd1: regWord = mtimecmp;
      3'd2: regWord[2:0] = {pend, irqEn, en};
      3'd3: regWord[PRESC_W-1:0] = prescale;
`ifdef DIAGV2_TIMER_AUTORELOAD_EN
      3'd4: regWord = reload;
`endif
      default: ;
    endcase
    laneData = regWord >> {byteOff, 3'b000};
    case (sizeSel)
      2'd0:    rdVal = {{(DATA_W-8){laneData[7] & ~memType[2]}}, laneData[7:0]};
      2'd1:    rdVal = {{(DATA_W-16){laneData[15] & ~memType[2]}}, laneData[15:0]};
      2'd2:    rdVal = {{(DATA_W-32){laneData[31] & ~memType[2]}}, laneData[31:0]};
      default: rdVal = laneData;
    endcase
    rd = (sel && !misaligned) ? rdVal : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      en        <= 1'b0;
      irqEn     <= 1'b0;
      pend      <= 1'b0;
      prescale  <= '0;
      pcnt      <= '0;
      timer_irq <= 1'b0;
`ifdef DIAGV2_TIMER_AUTORELOAD_EN
      reload    <= '0;
`endif
    end else begin
      if (wrPresc || tick) pcnt <= '0;
      else if (en)         pcnt <= pcnt + 1'b1;

      if (wrMtime)   mtime <= mtimeWr;
      else if (tick) mtime <= mtime + 1'b1;

      if (wrCmp) mtimecmp <= cmpWr;
`ifdef DIAGV2_TIMER_AUTORELOAD_EN
      else if (reloadHit) mtimecmp <= mtimecmp + reload;
      if (wrReload) reload <= reloadWr;
`endif

      if (wrCtrl) begin
        en    <= ctrlWr[0];
        irqEn <= ctrlWr[1];
      end
      pend <= match | (pend & ~pendClr);

      if (wrPresc) prescale <= prescWr[PRESC_W-1:0];

      timer_irq <= pend & irqEn;
    end
  end

endmodule

// File: tb/tb_diagv2_mmio_timer.sv
// tb/tb_diagv2_mmio_timer.sv - directed self-checking bench for diagv2_mmio_timer
module tb_diagv2_mmio_timer;

  localparam logic [2:0]  MT_B   = 3'b000;
  localparam logic [2:0]  MT_H   = 3'b001;
  localparam logic [2:0]  MT_D   = 3'b011;
  localparam logic [2:0]  MT_BU  = 3'b100;
  localparam logic [63:0] A_MTIME  = 64'h00;
  localparam logic [63:0] A_CMP    = 64'h08;
  localparam logic [63:0] A_CTRL   = 64'h10;
  localparam logic [63:0] A_PRESC  = 64'h18;
  localparam logic [63:0] A_RELOAD = 64'h20;
  localparam logic [63:0] A_HOLE   = 64'h28;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  memType = 3'b000;
  logic [63:0] addr = '0;
  logic [63:0] wd = '0;
  logic [63:0] rd;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  diagv2_mmio_timer dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .memType(memType),
    .addr(addr), .wd(wd), .rd(rd), .timer_irq(timer_irq)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [63:0] a, input logic [2:0] mt, input logic [63:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; memType = mt; wd = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [63:0] a, input logic [2:0] mt,
                           input logic [63:0] exp);
    sel = 1'b1; we = 1'b0; addr = a; memType = mt;
    #1;
    checkVal(tag, rd, exp);
    sel = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyReset();
    readCheck("reset_mtime", A_MTIME, MT_D, 64'h0);
    readCheck("reset_cmp", A_CMP, MT_D, 64'hFFFF_FFFF_FFFF_FFFF);
    checkVal("reset_irq", 64'(timer_irq), 64'h0);

    // asynchronous reset in the middle of counting with irq asserted
    busWrite(A_CMP, MT_D, 64'h0);
    busWrite(A_CTRL, MT_D, 64'h3);
    busWrite(A_MTIME, MT_D, 64'h55);
    readCheck("pre_rst_mtime", A_MTIME, MT_D, 64'h55);
    checkVal("pre_rst_irq", 64'(timer_irq), 64'h1);
    #2 reset = 1'b0;
    #1 checkVal("async_irq", 64'(timer_irq), 64'h0);
    readCheck("async_mtime", A_MTIME, MT_D, 64'h0);
    readCheck("async_cmp", A_CMP, MT_D, 64'hFFFF_FFFF_FFFF_FFFF);
    readCheck("async_ctrl", A_CTRL, MT_D, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    readCheck("post_rst_mtime", A_MTIME, MT_D, 64'h0);

    // prescaler 3 -> one tick every 4 cycles
    applyReset();
    busWrite(A_PRESC, MT_D, 64'h3);
    busWrite(A_CTRL, MT_D, 64'h1);
    repeat (40) @(posedge clk);
    #1;
    readCheck("presc3_mtime", A_MTIME, MT_D, 64'd10);
    busWrite(A_CTRL, MT_D, 64'h0);
    busWrite(A_PRESC, MT_D, 64'h0);
    busWrite(A_CTRL, MT_D, 64'h1);
    readCheck("presc0_start", A_MTIME, MT_D, 64'd10);
    @(posedge clk); #1;
    readCheck("presc0_1", A_MTIME, MT_D, 64'd11);
    repeat (5) @(posedge clk); #1;
    readCheck("presc0_6", A_MTIME, MT_D, 64'd16);
    readCheck("prescale_rb", A_PRESC, MT_D, 64'h0);

    // compare, PEND, irq and W1C
    applyReset();
    busWrite(A_CMP, MT_D, 64'd20);
    busWrite(A_CTRL, MT_D, 64'h3);
    repeat (20) @(posedge clk); #1;
    readCheck("cmp_mtime20", A_MTIME, MT_D, 64'd20);
    readCheck("cmp_pend_pre", A_CTRL, MT_D, 64'h3);
    @(posedge clk); #1;
    readCheck("cmp_pend_set", A_CTRL, MT_D, 64'h7);
    checkVal("cmp_irq_lag", 64'(timer_irq), 64'h0);
    @(posedge clk); #1;
    checkVal("cmp_irq_high", 64'(timer_irq), 64'h1);
    busWrite(A_CTRL, MT_D, 64'h7);
    readCheck("w1c_set_wins", A_CTRL, MT_D, 64'h7);
    busWrite(A_CMP, MT_D, 64'd1000);
    readCheck("cmp_raise_keeps", A_CTRL, MT_D, 64'h7);
    busWrite(A_CTRL, MT_D, 64'h7);
    readCheck("w1c_clear", A_CTRL, MT_D, 64'h3);
    checkVal("w1c_irq_hold", 64'(timer_irq), 64'h1);
    @(posedge clk); #1;
    checkVal("w1c_irq_drop", 64'(timer_irq), 64'h0);

    // byte lanes, sign extension, misalignment, unmapped offset
    applyReset();
    busWrite(A_MTIME, MT_D, 64'h1122_3344_5566_7788);
    busWrite(A_MTIME + 64'd3, MT_B, 64'hAA);
    readCheck("sb_merge", A_MTIME, MT_D, 64'h1122_3344_AA66_7788);
    readCheck("lb_sign", A_MTIME + 64'd3, MT_B, 64'hFFFF_FFFF_FFFF_FFAA);
    readCheck("lbu_zero", A_MTIME + 64'd3, MT_BU, 64'h0000_0000_0000_00AA);
    busWrite(A_MTIME + 64'd1, MT_H, 64'hBEEF);
    readCheck("sh_misalign", A_MTIME, MT_D, 64'h1122_3344_AA66_7788);
    readCheck("lh_misalign", A_MTIME + 64'd1, MT_H, 64'h0);
    readCheck("lh_aligned", A_MTIME + 64'd6, MT_H, 64'h0000_0000_0000_1122);
    busWrite(A_HOLE, MT_D, 64'hDEAD_BEEF);
    readCheck("hole_read", A_HOLE, MT_D, 64'h0);

    // wrap-around and software write beating a tick
    applyReset();
    busWrite(A_MTIME, MT_D, 64'hFFFF_FFFF_FFFF_FFFE);
    busWrite(A_CTRL, MT_D, 64'h1);
    repeat (2) @(posedge clk); #1;
    readCheck("wrap_zero", A_MTIME, MT_D, 64'h0);
    busWrite(A_MTIME, MT_D, 64'h100);
    readCheck("wr_beats_tick", A_MTIME, MT_D, 64'h100);

    // auto-reload (or its absence)
    applyReset();
    busWrite(A_CMP, MT_D, 64'd10);
    busWrite(A_RELOAD, MT_D, 64'd10);
    busWrite(A_CTRL, MT_D, 64'h1);
    repeat (9) @(posedge clk); #1;
    readCheck("rl_cmp_before", A_CMP, MT_D, 64'd10);
    @(posedge clk); #1;
`ifdef DIAGV2_TIMER_AUTORELOAD_EN
    readCheck("rl_cmp_at10", A_CMP, MT_D, 64'd20);
    repeat (10) @(posedge clk); #1;
    readCheck("rl_cmp_at20", A_CMP, MT_D, 64'd30);
    repeat (10) @(posedge clk); #1;
    readCheck("rl_cmp_at30", A_CMP, MT_D, 64'd40);
    readCheck("rl_reload_rb", A_RELOAD, MT_D, 64'd10);
`else
    readCheck("rl_cmp_at10", A_CMP, MT_D, 64'd10);
    repeat (10) @(posedge clk); #1;
    readCheck("rl_cmp_at20", A_CMP, MT_D, 64'd10);
    readCheck("rl_reload_rb", A_RELOAD, MT_D, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
